life_engine: RTL and testbench
==============================

// Module: life_engine
// PURPOSE
//  Parametrised Conway Game-of-Life core (rule B3/S23) on a ROWS x COLS grid.
//  Successor to the fixed 8x8 game: run/step modes, programmable update period,
//  generation counter, and auto-halt on still-life or extinction.
//  Sits between the seed source (LFSR) and the HDMI grid renderer.
// PARAMETERS
//  ROWS    8   grid rows (>=3)
//  COLS    8   grid columns (>=3)
//  PERIOD  4   clk cycles per generation in RUN (>=1)
//  GEN_W   16  generation counter width
// PORTS
//  clk         in   1          system clock
//  reset       in   1          synchronous, active-high reset
//  load        in   1          pulse: grid <= seed
//  seed        in   ROWS*COLS  initial pattern; cell (r,c) = bit r*COLS+c
//  run         in   1          level: free-run generations every PERIOD cycles
//  step        in   1          pulse: advance exactly one generation (IDLE only)
//  grid        out  ROWS*COLS  current generation, registered
//  generation  out  GEN_W      generations applied since last load/reset
//  running     out  1          state==RUN
//  done        out  1          state==DONE (halted: stable or extinct)
//  stable      out  1          combinational: next grid == grid
//  extinct     out  1          combinational: grid == 0
// BEHAVIOUR
//  - Reset (sync, active-high): grid=0, generation=0, timer=0, state=IDLE;
//    running=0, done=0; extinct=1, stable=1 follow from grid=0.
//  - Next-state logic combinational over all cells: live cell with 2 or 3 live
//    neighbours survives; dead cell with exactly 3 becomes live; else dead.
//    Neighbour count 0..8, 4 bits; edge handling per CONFIGURATION.
//  - Priority per cycle: reset > load > state-machine action.
//  - load (any state): grid<=seed, generation<=0, timer<=0, state<=IDLE.
//    Takes precedence over a same-cycle step/tick.
//  - States:
//    IDLE: step=1 -> grid<=next, generation+=1 (visible next cycle, latency 1);
//          step applied even if stable. run=1 (and no step) -> RUN, timer<=0.
//    RUN : timer counts 0..PERIOD-1. At timer==PERIOD-1 (tick): if stable or
//          extinct -> DONE, grid/generation unchanged; else grid<=next,
//          generation+=1, timer<=0. step ignored. run=0 -> IDLE, timer<=0,
//          no update that cycle (run=0 beats tick).
//    DONE: grid frozen; step ignored; run=0 -> IDLE. Only load leaves with run=1.
//  - generation wraps modulo 2^GEN_W (no saturation).
//  - PERIOD=1: update every cycle while in RUN.
//  - load mid-period discards partial timer count; if run stays high,
//    RUN re-entered next cycle with timer=0.
// CONFIGURATION
//  - WRAP_EN defined: toroidal grid; neighbour row (r+-1) mod ROWS, col
//    (c+-1) mod COLS.
//  - WRAP_EN undefined: bounded grid; neighbours outside 0..ROWS-1/0..COLS-1
//    count as dead.
// TESTING
//  1. reset=1 one cycle -> grid=0, generation=0, running=0, done=0, extinct=1.
//  2. 8x8, load blinker at (3,2),(3,3),(3,4); step -> next cycle grid at
//     (2,3),(3,3),(4,3), generation=1; step -> original row, generation=2.
//  3. PERIOD=4, load 2x2 block at (1,1)-(2,2); run=1 -> running=1, at first
//     tick (4 cycles) done=1, running=0, generation=0, grid unchanged.
//  4. Blinker at (0,2),(0,3),(0,4); step -> WRAP_EN: (7,3),(0,3),(1,3);
//     no WRAP_EN: (0,3),(1,3) only.
//  5. RUN with blinker, PERIOD=4; load new seed at timer==2 -> grid=seed,
//     generation=0 next cycle; first update 4 cycles after RUN re-entry.
//  6. GEN_W=4, blinker, 16 step pulses -> generation=0, grid equals seed;
//     extinct pattern (single cell) in RUN -> tick 1 grid=0, tick 2 done=1.

Source files
------------

// File: rtl/life_engine_if.sv
// Bus between the seed/control source and the Game-of-Life core.
// The master side drives the load/run/step controls and the seed. The slave
// side, which is the core, returns the grid, the generation count and status.
interface life_engine_if #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int GEN_W = 16
);
   logic                   load;
   logic [ROWS*COLS-1:0]   seed;
   logic                   run;
   logic                   step;
   logic [ROWS*COLS-1:0]   grid;
   logic [GEN_W-1:0]       generation;
   logic                   running;
   logic                   done;
   logic                   stable;
   logic                   extinct;

   modport master (
      output load, seed, run, step,
      input  grid, generation, running, done, stable, extinct
   );

   modport slave (
      input  load, seed, run, step,
      output grid, generation, running, done, stable, extinct
   );
endinterface

// File: rtl/life_engine.sv
// Parametrised Conway Game-of-Life core, rule B3/S23, on a ROWS x COLS grid.
// Cell (r,c) is stored in bit r*COLS+c.
// Optional macro WRAP_EN:
//   defined   -> the grid is toroidal (edges wrap around).
//   undefined -> the grid is bounded; cells outside the grid count as dead.
// Modes:
//   step -> advances exactly one generation while IDLE.
//   run  -> free-runs one generation every PERIOD cycles.
// The core halts in DONE when the grid becomes a still life or goes extinct.
module life_engine #(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int PERIOD = 4,
   parameter int GEN_W  = 16
) (
   input  logic          clk,
   input  logic          reset,
   life_engine_if.slave  bus
);

   localparam int CELLS   = ROWS * COLS;
   localparam int IDX_W   = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam int TIMER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [TIMER_W-1:0] TICK = TIMER_W'(PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [CELLS-1:0]    grid_q;
   logic [CELLS-1:0]    next_grid;
   logic [GEN_W-1:0]    gen_q;
   logic [TIMER_W-1:0]  timer;
   logic                stable;
   logic                extinct;

   // Live-neighbour count (0..8) of cell (r,c).
   // Out-of-grid neighbours either wrap around or are treated as dead.
   function automatic logic [3:0] count_neighbours(
      input logic [CELLS-1:0] g,
      input int               r,
      input int               c
   );
      logic [3:0]       n;
      logic [IDX_W-1:0] idx;
      int               rr;
      int               cc;
      n = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0)) begin
               rr = r + dr;
               cc = c + dc;
`ifdef WRAP_EN
               rr  = (rr + ROWS) % ROWS;
               cc  = (cc + COLS) % COLS;
               idx = IDX_W'(rr * COLS + cc);
               n   = n + {3'b000, g[idx]};
`else
               if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                  idx = IDX_W'(rr * COLS + cc);
                  n   = n + {3'b000, g[idx]};
               end
`endif
            end
         end
      end
      return n;
   endfunction

   // Next generation of every cell.
   // A cell is born with exactly 3 neighbours. A live cell survives with 2 or 3.
   always_comb begin
      next_grid = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            logic [3:0]       n;
            logic [IDX_W-1:0] idx;
            idx = IDX_W'(r * COLS + c);
            n   = count_neighbours(grid_q, r, c);
            next_grid[idx] = (n == 4'd3) || (grid_q[idx] && n == 4'd2);
         end
      end
   end

   assign stable  = (next_grid == grid_q);
   assign extinct = (grid_q == '0);

   // Control FSM with priority reset > load > state action.
   // Only a RUN tick on a still or extinct grid halts into DONE; any other tick
   // applies the next generation.
   always_ff @(posedge clk) begin
      if (reset) begin
         grid_q <= '0;
         gen_q  <= '0;
         timer  <= '0;
         state  <= IDLE;
      end else if (bus.load) begin
         grid_q <= bus.seed;
         gen_q  <= '0;
         timer  <= '0;
         state  <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.step) begin
                  grid_q <= next_grid;
                  gen_q  <= gen_q + GEN_W'(1);
               end else if (bus.run) begin
                  timer <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (!bus.run) begin
                  timer <= '0;
                  state <= IDLE;
               end else if (timer == TICK) begin
                  if (stable || extinct) begin
                     state <= DONE;
                  end else begin
                     grid_q <= next_grid;
                     gen_q  <= gen_q + GEN_W'(1);
                     timer  <= '0;
                  end
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            DONE: begin
               if (!bus.run) begin
                  state <= IDLE;
               end
            end
            default: begin
               timer <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.grid       = grid_q;
   assign bus.generation = gen_q;
   assign bus.running    = (state == RUN);
   assign bus.done       = (state == DONE);
   assign bus.stable     = stable;
   assign bus.extinct    = extinct;

endmodule

// File: tb/tb_life_engine.sv
// Testbench for life_engine.
// Instance u_dut uses an 8x8 grid with PERIOD=4 and GEN_W=16.
// Instance u_dut4 uses PERIOD=1 and GEN_W=4.
// Each vector drives one cycle of inputs and queues the outputs expected after
// that edge. The queued record is then popped and compared with the outputs.
module tb_life_engine;

   localparam logic [63:0] BLK_H  = 64'h0000_0000_1C00_0000;
   localparam logic [63:0] BLK_V  = 64'h0000_0008_0808_0000;
   localparam logic [63:0] EDGE_H = 64'h0000_0000_0000_001C;
`ifdef WRAP_EN
   localparam logic [63:0] EDGE_N = 64'h0800_0000_0000_0808;
`else
   localparam logic [63:0] EDGE_N = 64'h0000_0000_0000_0808;
`endif
   localparam logic [63:0] BLOCK  = 64'h0000_0000_0006_0600;
   localparam logic [63:0] SINGLE = 64'h0000_0010_0000_0000;

   typedef struct {
      logic        sel;
      logic        rst;
      logic        load;
      logic        run;
      logic        step;
      logic [63:0] seed;
      logic [63:0] grid;
      logic [15:0] gen;
      logic        running;
      logic        done;
      logic        stable;
      logic        extinct;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic reset4;
   int   checks   = 0;
   int   failures = 0;
   int   vec_id   = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   life_engine_if #(.ROWS(8), .COLS(8), .GEN_W(16)) bus ();
   life_engine_if #(.ROWS(8), .COLS(8), .GEN_W(4))  bus4 ();

   life_engine #(.ROWS(8), .COLS(8), .PERIOD(4), .GEN_W(16)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   life_engine #(.ROWS(8), .COLS(8), .PERIOD(1), .GEN_W(4)) u_dut4 (
      .clk   (clk),
      .reset (reset4),
      .bus   (bus4)
   );

   // Builds one vector from its inputs and the outputs expected after the edge.
   function automatic vec_t mk(
      input logic sel, input logic rst, input logic load, input logic run,
      input logic step, input logic [63:0] seed, input logic [63:0] grid,
      input logic [15:0] gen, input logic running, input logic done,
      input logic stable, input logic extinct
   );
      vec_t v;
      v.sel = sel;   v.rst = rst;   v.load = load;  v.run = run;
      v.step = step; v.seed = seed; v.grid = grid;  v.gen = gen;
      v.running = running; v.done = done; v.stable = stable; v.extinct = extinct;
      return v;
   endfunction

   // Counts one comparison and reports it if it differs.
   task automatic cmp(input string name, input int id,
                      input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s vec %0d: got %h expected %h", name, id, act, exp);
      end
   endtask

   // Drives one cycle of inputs to the selected instance.
   // Queues the expected outputs and returns just after the active edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      if (v.sel) begin
         reset4 = v.rst;  bus4.load = v.load; bus4.run = v.run;
         bus4.step = v.step; bus4.seed = v.seed;
      end else begin
         reset = v.rst;   bus.load = v.load;  bus.run = v.run;
         bus.step = v.step;  bus.seed = v.seed;
      end
      exp_q.push_back(v);
      @(posedge clk);
      #1;
   endtask

   // Pops the oldest expectation and compares it with the selected instance.
   task automatic checkOutput();
      vec_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard vec %0d: got empty queue expected entry", vec_id);
         return;
      end
      e = exp_q.pop_front();
      if (e.sel) begin
         cmp("grid4",    vec_id, bus4.grid, e.grid);
         cmp("gen4",     vec_id, {60'd0, bus4.generation}, {48'd0, e.gen});
         cmp("running4", vec_id, {63'd0, bus4.running}, {63'd0, e.running});
         cmp("done4",    vec_id, {63'd0, bus4.done},    {63'd0, e.done});
         cmp("stable4",  vec_id, {63'd0, bus4.stable},  {63'd0, e.stable});
         cmp("extinct4", vec_id, {63'd0, bus4.extinct}, {63'd0, e.extinct});
      end else begin
         cmp("grid",     vec_id, bus.grid, e.grid);
         cmp("gen",      vec_id, {48'd0, bus.generation}, {48'd0, e.gen});
         cmp("running",  vec_id, {63'd0, bus.running}, {63'd0, e.running});
         cmp("done",     vec_id, {63'd0, bus.done},    {63'd0, e.done});
         cmp("stable",   vec_id, {63'd0, bus.stable},  {63'd0, e.stable});
         cmp("extinct",  vec_id, {63'd0, bus.extinct}, {63'd0, e.extinct});
      end
      vec_id++;
   endtask

   initial begin
      reset = 1'b1;  bus.load = 1'b0;  bus.run = 1'b0;  bus.step = 1'b0;  bus.seed = '0;
      reset4 = 1'b1; bus4.load = 1'b0; bus4.run = 1'b0; bus4.step = 1'b0; bus4.seed = '0;

      //             sel rst ld run stp seed    grid    gen run dn st ex
      // reset, blinker stepping, idle hold, edge blinker
      vecs.push_back(mk(0, 1, 0, 0, 0, 64'd0,  64'd0,  0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, BLK_H,  BLK_H,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 64'd0,  BLK_V,  1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 64'd0,  BLK_H,  2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 64'd0,  BLK_H,  2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, EDGE_H, EDGE_H, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 64'd0,  EDGE_N, 1, 0, 0, 0, 0));
      // still life halts at first tick; DONE holds with run=1 and ignores step
      vecs.push_back(mk(0, 0, 1, 0, 0, BLOCK,  BLOCK,  0, 0, 0, 1, 0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0, BLOCK, 0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0,  BLOCK,  0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 64'd0,  BLOCK,  0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 64'd0,  BLOCK,  0, 0, 0, 1, 0));
      // load at timer==2 while running, then RUN re-entry and first update
      vecs.push_back(mk(0, 0, 1, 0, 0, BLK_H,  BLK_H,  0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0, BLK_H, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, BLK_V,  BLK_V,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0,  BLK_V,  0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 64'd0,  BLK_V,  0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0,  BLK_V,  0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0,  BLK_V,  0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0,  BLK_H,  1, 1, 0, 0, 0));
      // run=0 beats a tick
      vecs.push_back(mk(0, 0, 0, 0, 0, 64'd0,  BLK_H,  1, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0, BLK_H, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 64'd0,  BLK_H,  1, 0, 0, 0, 0));
      // single cell dies at tick 1, halts at tick 2
      vecs.push_back(mk(0, 0, 1, 0, 0, SINGLE, SINGLE, 0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0, SINGLE, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0,  64'd0,  1, 1, 0, 1, 1));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0, 64'd0, 1, 1, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0,  64'd0,  1, 0, 1, 1, 1));
      // load leaves DONE with run held high; load beats a same-cycle step
      vecs.push_back(mk(0, 0, 1, 1, 0, BLK_H,  BLK_H,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 64'd0,  BLK_H,  0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 64'd0,  BLK_H,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, BLOCK,  BLOCK,  0, 0, 0, 1, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput();
      end

      // GEN_W=4 wrap over 16 steps, then PERIOD=1 updates every RUN cycle
      applyStimulus(mk(1, 1, 0, 0, 0, 64'd0, 64'd0, 0, 0, 0, 1, 1));
      checkOutput();
      applyStimulus(mk(1, 0, 1, 0, 0, BLK_H, BLK_H, 0, 0, 0, 0, 0));
      checkOutput();
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(mk(1, 0, 0, 0, 1, 64'd0, (i % 2 == 1) ? BLK_V : BLK_H,
                          16'(i % 16), 0, 0, 0, 0));
         checkOutput();
      end
      applyStimulus(mk(1, 0, 0, 1, 0, 64'd0, BLK_H, 0, 1, 0, 0, 0));
      checkOutput();
      applyStimulus(mk(1, 0, 0, 1, 0, 64'd0, BLK_V, 1, 1, 0, 0, 0));
      checkOutput();
      applyStimulus(mk(1, 0, 0, 1, 0, 64'd0, BLK_H, 2, 1, 0, 0, 0));
      checkOutput();
      applyStimulus(mk(1, 0, 0, 0, 0, 64'd0, BLK_H, 2, 0, 0, 0, 0));
      checkOutput();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
